// File: rtl/ascon_perm_arbiter_if.sv
// Requester handshake and round-datapath signals of the Ascon permutation arbiter.
// slave: arbiter side; master: requesters plus round datapath.
interface ascon_perm_arbiter_if;
    logic         req_a;
    logic         req_b;
    logic [3:0]   nr_a;
    logic [3:0]   nr_b;
    logic [319:0] sa;
    logic [319:0] sb;
    logic         gnt_a;
    logic         gnt_b;
    logic         done_a;
    logic         done_b;
    logic [319:0] result;
    logic         busy;
    logic [1:0]   rcmode;
    logic [3:0]   constti;
    logic [63:0]  Xi0, Xi1, Xi2, Xi3, Xi4;
    logic [63:0]  Xo0, Xo1, Xo2, Xo3, Xo4;

    modport slave (
        input  req_a, req_b, nr_a, nr_b, sa, sb, Xo0, Xo1, Xo2, Xo3, Xo4,
        output gnt_a, gnt_b, done_a, done_b, result, busy, rcmode, constti,
               Xi0, Xi1, Xi2, Xi3, Xi4
    );

    modport master (
        output req_a, req_b, nr_a, nr_b, sa, sb, Xo0, Xo1, Xo2, Xo3, Xo4,
        input  gnt_a, gnt_b, done_a, done_b, result, busy, rcmode, constti,
               Xi0, Xi1, Xi2, Xi3, Xi4
    );
endinterface

// File: rtl/ascon_perm_arbiter.sv
// Two-requester arbiter sequencing an external one-round Ascon datapath for nr rounds.
// Define ASCON_ARB_FIXED_PRIO_EN for fixed A-priority instead of round-robin.
//
// state | meaning
// IDLE  | waiting; grants a request and issues the first round in the same cycle
// RUN   | feeding datapath output back, one round per cycle
// DONE  | result valid, done pulse to owner, datapath idle
module ascon_perm_arbiter (
    input logic                  clk,
    input logic                  nRST,
    ascon_perm_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic       owner, owner_nxt;      // 0: A, 1: B
    logic [3:0] ctr, ctr_nxt;          // round index issued in the current RUN cycle
    logic       any_req;
    logic       win_b;
    logic [3:0] nr_raw;
    logic [3:0] nr_eff;
    logic [3:0] ct0;

`ifndef ASCON_ARB_FIXED_PRIO_EN
    logic       last_b;
`endif

    always_comb begin
        any_req = bus.req_a | bus.req_b;
`ifdef ASCON_ARB_FIXED_PRIO_EN
        win_b   = ~bus.req_a;
`else
        win_b   = bus.req_b & (~bus.req_a | ~last_b);
`endif
        nr_raw  = win_b ? bus.nr_b : bus.nr_a;
        nr_eff  = (nr_raw == 4'd0 || nr_raw > 4'd12) ? 4'd12 : nr_raw;
        ct0     = 4'd12 - nr_eff;
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ctr_nxt     = ctr;
        bus.gnt_a   = 1'b0;
        bus.gnt_b   = 1'b0;
        bus.done_a  = 1'b0;
        bus.done_b  = 1'b0;
        bus.busy    = 1'b0;
        bus.rcmode  = 2'b00;
        bus.constti = 4'd0;
        bus.result  = '0;
        {bus.Xi0, bus.Xi1, bus.Xi2, bus.Xi3, bus.Xi4} = 320'd0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    bus.gnt_a   = ~win_b;
                    bus.gnt_b   = win_b;
                    bus.busy    = 1'b1;
                    bus.rcmode  = 2'b01;
                    bus.constti = ct0;
                    {bus.Xi0, bus.Xi1, bus.Xi2, bus.Xi3, bus.Xi4} = win_b ? bus.sb : bus.sa;
                    owner_nxt   = win_b;
                    if (ct0 == 4'd11) begin
                        state_nxt = DONE;
                        ctr_nxt   = 4'd0;
                    end else begin
                        state_nxt = RUN;
                        ctr_nxt   = ct0 + 4'd1;
                    end
                end
            end
            RUN: begin
                bus.busy    = 1'b1;
                bus.rcmode  = 2'b01;
                bus.constti = ctr;
                bus.Xi0     = bus.Xo0;
                bus.Xi1     = bus.Xo1;
                bus.Xi2     = bus.Xo2;
                bus.Xi3     = bus.Xo3;
                bus.Xi4     = bus.Xo4;
                if (ctr == 4'd11) begin
                    state_nxt = DONE;
                    ctr_nxt   = 4'd0;
                end else begin
                    ctr_nxt   = ctr + 4'd1;
                end
            end
            DONE: begin
                bus.busy    = 1'b1;
                bus.done_a  = ~owner;
                bus.done_b  = owner;
                bus.result  = {bus.Xo0, bus.Xo1, bus.Xo2, bus.Xo3, bus.Xo4};
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // outputs are combinational, so reset must mask them directly
        if (!nRST) begin
            bus.gnt_a   = 1'b0;
            bus.gnt_b   = 1'b0;
            bus.done_a  = 1'b0;
            bus.done_b  = 1'b0;
            bus.busy    = 1'b0;
            bus.rcmode  = 2'b00;
            bus.constti = 4'd0;
            bus.result  = '0;
            {bus.Xi0, bus.Xi1, bus.Xi2, bus.Xi3, bus.Xi4} = 320'd0;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            owner <= 1'b0;
            ctr   <= 4'd0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ctr   <= ctr_nxt;
        end
    end

`ifndef ASCON_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            last_b <= 1'b1;
        else if (state == IDLE && any_req)
            last_b <= win_b;
    end
`endif
endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// Directed/randomized bench for ascon_perm_arbiter with a behavioural Ascon round datapath.
module tb_ascon_perm_arbiter;
    logic clk = 1'b0;
    logic nRST;
    int   n_tests = 0;
    int   n_fail  = 0;

    ascon_perm_arbiter_if ifc ();

    ascon_perm_arbiter dut (.clk(clk), .nRST(nRST), .bus(ifc));

    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round with round index i of the 12-round schedule.
    function automatic logic [319:0] rnd(input logic [319:0] s, input int i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ 64'(((15 - i) << 4) | i);
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic int norm(input logic [3:0] nr);
        return (nr == 4'd0 || nr > 4'd12) ? 12 : int'(nr);
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input int eff);
        logic [319:0] r = s;
        for (int i = 12 - eff; i < 12; i++) r = rnd(r, i);
        return r;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom)};
        return r;
    endfunction

    // External datapath: round(Xi, constti) registered one cycle later.
    always @(posedge clk)
        if (ifc.rcmode == 2'b01)
            {ifc.Xo0, ifc.Xo1, ifc.Xo2, ifc.Xo3, ifc.Xo4} <=
                rnd({ifc.Xi0, ifc.Xi1, ifc.Xi2, ifc.Xi3, ifc.Xi4}, int'(ifc.constti));

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input bit b, input logic v);
        if (b) ifc.req_b = v;
        else   ifc.req_a = v;
    endtask

    task automatic idle_chk(input string p);
        chk({p, "_busy"},    ifc.busy, 0);
        chk({p, "_rcmode"},  ifc.rcmode, 0);
        chk({p, "_constti"}, ifc.constti, 0);
        chk({p, "_xi"},      {ifc.Xi0, ifc.Xi1, ifc.Xi2, ifc.Xi3, ifc.Xi4}, 0);
        chk({p, "_gnt"},     {ifc.gnt_a, ifc.gnt_b}, 0);
        chk({p, "_done"},    {ifc.done_a, ifc.done_b}, 0);
        chk({p, "_result"},  ifc.result, 0);
    endtask

    // Called in the expected grant cycle with inputs settled; ends in the done cycle.
    task automatic expect_op(input string p, input bit b, input int drop_at, input int raise_at);
        logic [319:0] s;
        logic [319:0] ex;
        int eff;
        s   = b ? ifc.sb : ifc.sa;
        eff = norm(b ? ifc.nr_b : ifc.nr_a);
        ex  = perm(s, eff);
        chk({p, "_gnt_own"},   b ? ifc.gnt_b : ifc.gnt_a, 1);
        chk({p, "_gnt_other"}, b ? ifc.gnt_a : ifc.gnt_b, 0);
        chk({p, "_busy0"},     ifc.busy, 1);
        chk({p, "_rcmode0"},   ifc.rcmode, 1);
        chk({p, "_constti0"},  ifc.constti, 12 - eff);
        chk({p, "_xi0"},       {ifc.Xi0, ifc.Xi1, ifc.Xi2, ifc.Xi3, ifc.Xi4}, s);
        for (int k = 1; k < eff; k++) begin
            step();
            if (k == drop_at)  set_req(b, 1'b0);
            if (k == raise_at) set_req(!b, 1'b1);
            #1;
            chk({p, "_constti"}, ifc.constti, 12 - eff + k);
            chk({p, "_rcmode"},  ifc.rcmode, 1);
            chk({p, "_busy"},    ifc.busy, 1);
            chk({p, "_gnt_run"}, {ifc.gnt_a, ifc.gnt_b}, 0);
            chk({p, "_done_run"},{ifc.done_a, ifc.done_b}, 0);
        end
        step();
        #1;
        chk({p, "_done_own"},   b ? ifc.done_b : ifc.done_a, 1);
        chk({p, "_done_other"}, b ? ifc.done_a : ifc.done_b, 0);
        chk({p, "_gnt_done"},   {ifc.gnt_a, ifc.gnt_b}, 0);
        chk({p, "_rcmode_d"},   ifc.rcmode, 0);
        chk({p, "_busy_d"},     ifc.busy, 1);
        chk({p, "_result"},     ifc.result, ex);
        set_req(b, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit fw;
        nRST = 1'b0;
        ifc.req_a = 1'b1; ifc.req_b = 1'b0;
        ifc.nr_a = 4'd12; ifc.nr_b = 4'd12;
        ifc.sa = '0; ifc.sb = '0;
        #3;
        idle_chk("reset_req");
        ifc.req_a = 1'b0;
        step(); step();
        nRST = 1'b1;
        step(); #1;
        idle_chk("post_reset");

        // single A, 12 rounds of the zero state
        step(); ifc.req_a = 1'b1; ifc.nr_a = 4'd12; ifc.sa = '0; #1;
        expect_op("a12", 0, -1, -1);
        step(); #1; idle_chk("a12_idle");

        // single B, 6 rounds
        step(); ifc.req_b = 1'b1; ifc.nr_b = 4'd6; ifc.sb = rand320(); #1;
        expect_op("b6", 1, -1, -1);
        step(); #1; idle_chk("b6_idle");

        // tie after reset-like pointer: A, then B one cycle after A's done
        step();
        ifc.req_a = 1'b1; ifc.req_b = 1'b1; ifc.nr_a = 4'd8; ifc.nr_b = 4'd8;
        ifc.sa = rand320(); ifc.sb = rand320(); #1;
        expect_op("tie1_a", 0, -1, -1);
        step(); #1;
        expect_op("tie1_b", 1, -1, -1);
        step(); #1; idle_chk("tie1_idle");

        // A served last, then a tie: B under round-robin, A under fixed priority
        step(); ifc.req_a = 1'b1; ifc.nr_a = 4'd3; ifc.sa = rand320(); #1;
        expect_op("solo_a", 0, -1, -1);
        step(); #1; idle_chk("solo_a_idle");
        step();
        ifc.req_a = 1'b1; ifc.req_b = 1'b1; ifc.nr_a = 4'd8; ifc.nr_b = 4'd8;
        ifc.sa = rand320(); ifc.sb = rand320(); #1;
`ifdef ASCON_ARB_FIXED_PRIO_EN
        fw = 1'b0;
`else
        fw = 1'b1;
`endif
        expect_op("tie2_first", fw, -1, -1);
        step(); #1;
        expect_op("tie2_second", !fw, -1, -1);
        step(); #1; idle_chk("tie2_idle");

        // out-of-range round counts behave as 12
        step(); ifc.req_a = 1'b1; ifc.nr_a = 4'd0; ifc.sa = rand320(); #1;
        expect_op("nr0", 0, -1, -1);
        step(); #1; idle_chk("nr0_idle");
        step(); ifc.req_a = 1'b1; ifc.nr_a = 4'd15; ifc.sa = rand320(); #1;
        expect_op("nr15", 0, -1, -1);
        step(); #1; idle_chk("nr15_idle");

        // reset at T+5 of a 12-round operation
        step(); ifc.req_a = 1'b1; ifc.nr_a = 4'd12; ifc.sa = rand320(); #1;
        chk("rst_gnt", ifc.gnt_a, 1);
        for (int k = 1; k < 5; k++) step();
        step();
        nRST = 1'b0; #1;
        idle_chk("rst_mid");
        ifc.req_a = 1'b0;
        step(); #1; idle_chk("rst_hold");
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); #1; idle_chk("rst_after");
        end
        step(); ifc.req_a = 1'b1; ifc.sa = rand320(); #1;
        expect_op("rst_rereq", 0, -1, -1);
        step(); #1; idle_chk("rst_rereq_idle");

        // A drops at T+1, B raises at T+3 and is granted at T+nr+1
        step();
        ifc.req_a = 1'b1; ifc.nr_a = 4'($urandom_range(6, 12));
        ifc.nr_b = 4'($urandom_range(1, 12));
        ifc.sa = rand320(); ifc.sb = rand320(); #1;
        expect_op("drop_a", 0, 1, 3);
        step(); #1;
        expect_op("late_b", 1, -1, -1);
        step(); #1; idle_chk("late_b_idle");

        // randomized single operations, any round count encoding
        for (int it = 0; it < 8; it++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            step();
            if (b) begin
                ifc.nr_b = 4'($urandom_range(0, 15)); ifc.sb = rand320();
            end else begin
                ifc.nr_a = 4'($urandom_range(0, 15)); ifc.sa = rand320();
            end
            set_req(b, 1'b1);
            #1;
            expect_op("rand", b, -1, -1);
            step(); #1; idle_chk("rand_idle");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
